// File: rtl/ioctl_ram_arbiter.sv
// ioctl_ram_arbiter
// Shares one single-port 64 KB RAM between the Z80 bus and the HPS cartridge
// download stream. CPU accesses own every cpu_ce cycle; downloaded bytes are
// queued in a small FIFO and written into the RAM on the idle cycles between
// CPU accesses. Also produces the end-of-load pulse (load_done).
//
// Optional feature macro: ARB_ROM_PROTECT_EN
//   When defined, CPU writes into the cartridge window (cpu_addr[15:14] ==
//   BASE_HI) are suppressed after a completed load, until reset or until a
//   new matching download starts.
module ioctl_ram_arbiter #(
    parameter int unsigned FIFO_AW    = 2,
    parameter logic [7:0]  LOAD_INDEX = 8'd1,
    parameter logic [1:0]  BASE_HI    = 2'b11
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    output logic [7:0]  cpu_rdata,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [13:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    input  logic [7:0]  ram_q,
    output logic        load_done,
    output logic        busy,
    output logic        overflow
);

    localparam int unsigned DEPTH = 1 << FIFO_AW;
    localparam int unsigned CW    = FIFO_AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] WAIT_CNT = CW'(DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [FIFO_AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                dl_q, dl_d;
    logic                ce_q, ce_d;
    logic [7:0]          rdata_q, rdata_d;
    logic                wait_q, wait_d;
    logic                overflow_q, overflow_d;

    // FIFO storage: entry = {byte offset[13:0], data[7:0]}
    logic [21:0]         fifo_mem [DEPTH];
    logic [21:0]         head;

    logic                match_dl;
    logic                push_req;
    logic                fifo_empty;
    logic                fifo_full;
    logic                pop;
    logic                push_acc;
    logic                push_drop;
    logic                dl_fall;
    logic                cpu_we_eff;

    assign head = fifo_mem[rd_ptr_q];

    // Decode push/pop: the CPU always wins, pops only fill idle cycles of an
    // active load, and a full FIFO still accepts a byte if a pop frees a slot.
    always_comb begin
        match_dl   = ioctl_download && (ioctl_index == LOAD_INDEX);
        push_req   = ioctl_wr && match_dl;
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_CNT);
        dl_fall    = dl_q && !ioctl_download;
        pop        = !reset && !cpu_ce && !fifo_empty &&
                     ((state_q == ST_DRAIN) || (state_q == ST_FLUSH));
        push_acc   = push_req && (!fifo_full || pop);
        push_drop  = push_req && fifo_full && !pop;
    end

    // Load sequencing: DRAIN while downloading, FLUSH after the download
    // falls until the FIFO is empty, then one DONE cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (match_dl)   state_d = ST_DRAIN;
            ST_DRAIN: if (dl_fall)    state_d = ST_FLUSH;
            ST_FLUSH: if (fifo_empty) state_d = ST_DONE;
            ST_DONE:                  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // FIFO pointers, occupancy and the registered backpressure/overflow flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + FIFO_AW'(push_acc);
        rd_ptr_d   = rd_ptr_q + FIFO_AW'(pop);
        count_d    = count_q + CW'(push_acc) - CW'(pop);
        wait_d     = (count_d >= WAIT_CNT);
        overflow_d = overflow_q || push_drop;
    end

    // CPU read data: capture ram_q one cycle after a CPU-owned cycle, else hold.
    always_comb begin
        ce_d    = cpu_ce;
        dl_d    = ioctl_download;
        rdata_d = ce_q ? ram_q : rdata_q;
    end

`ifdef ARB_ROM_PROTECT_EN
    logic protect_q, protect_d;

    // Arm protection on a completed load; a new matching download disarms it.
    always_comb begin
        protect_d = protect_q;
        if (state_q == ST_DONE) begin
            protect_d = 1'b1;
        end else if ((state_q == ST_IDLE) && match_dl) begin
            protect_d = 1'b0;
        end
    end

    // Protection flag register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            protect_q <= 1'b0;
        end else begin
            protect_q <= protect_d;
        end
    end

    assign cpu_we_eff = cpu_we && !(protect_q && (cpu_addr[15:14] == BASE_HI));
`else
    assign cpu_we_eff = cpu_we;
`endif

    // RAM port mux: CPU on ce cycles, FIFO head on pop cycles, else CPU
    // address with writes disabled.
    always_comb begin
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_we    = 1'b0;
        if (cpu_ce) begin
            ram_we = cpu_we_eff && !reset;
        end else if (pop) begin
            ram_addr  = {BASE_HI, head[21:8]};
            ram_wdata = head[7:0];
            ram_we    = 1'b1;
        end
    end

    // FIFO data write; contents need no reset since the pointers define validity.
    always_ff @(posedge clk_sys) begin
        if (push_acc) begin
            fifo_mem[wr_ptr_q] <= {ioctl_addr, ioctl_dout};
        end
    end

    // State, pointer and flag registers.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            dl_q       <= 1'b0;
            ce_q       <= 1'b0;
            rdata_q    <= 8'h00;
            wait_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            dl_q       <= dl_d;
            ce_q       <= ce_d;
            rdata_q    <= rdata_d;
            wait_q     <= wait_d;
            overflow_q <= overflow_d;
        end
    end

    assign cpu_rdata  = rdata_q;
    assign ioctl_wait = wait_q;
    assign load_done  = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE) || !fifo_empty;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ioctl_ram_arbiter.sv
// Testbench for ioctl_ram_arbiter: directed scenarios plus randomized
// download/CPU traffic, checked every cycle against a behavioural model.
module tb_ioctl_ram_arbiter;

    localparam int         DEPTH      = 4;
    localparam logic [7:0] LOAD_INDEX = 8'd1;
    localparam logic [1:0] BASE_HI    = 2'b11;
`ifdef ARB_ROM_PROTECT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    localparam int CE_MAN  = 0;
    localparam int CE_16   = 1;
    localparam int CE_ALL  = 2;
    localparam int CE_RAND = 3;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_ce = 1'b0;
    logic [15:0] cpu_addr = 16'h1234;
    logic [7:0]  cpu_wdata = 8'h00;
    logic        cpu_we = 1'b0;
    logic [7:0]  cpu_rdata;
    logic        ioctl_download = 1'b0;
    logic [7:0]  ioctl_index = 8'd0;
    logic        ioctl_wr = 1'b0;
    logic [13:0] ioctl_addr = 14'd0;
    logic [7:0]  ioctl_dout = 8'd0;
    logic        ioctl_wait;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_we;
    logic [7:0]  ram_q;
    logic        load_done;
    logic        busy;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int cycles = 0;
    int done_pulses = 0;
    int hi_writes = 0;
    int ce_mode = CE_MAN;
    int ce_cnt = 0;

    ioctl_ram_arbiter dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .cpu_ce         (cpu_ce),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_we         (cpu_we),
        .cpu_rdata      (cpu_rdata),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .ram_addr       (ram_addr),
        .ram_wdata      (ram_wdata),
        .ram_we         (ram_we),
        .ram_q          (ram_q),
        .load_done      (load_done),
        .busy           (busy),
        .overflow       (overflow)
    );

    always #5 clk_sys = ~clk_sys;

    // Single-port RAM with registered read (read-before-write).
    logic [7:0] mem [65536];
    always @(posedge clk_sys) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            if (ram_addr[15:14] == 2'b11) hi_writes <= hi_writes + 1;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [21:0] mq[$];       // bytes accepted but not yet in RAM
    bit          m_sess = 0;  // a load is being written (bytes may drain)
    bit          m_fallen = 0;// download has ended within this load
    bit          m_done = 0;  // this cycle is the end-of-load cycle
    bit          m_prot = 0;
    bit          m_wait = 0;
    bit          m_ovf = 0;
    bit          m_prev_ce = 0;
    bit          m_prev_dl = 0;
    logic [7:0]  m_rdata = 8'h00;

    initial begin : compare
        logic [15:0] e_addr;
        logic [7:0]  e_wdata;
        logic        e_we, m_pop, match, push_req, was_empty, nd;
        @(posedge clk_sys);
        forever begin
            @(negedge clk_sys);
            cycles++;
            if (cycles > 60000) begin
                $display("FAIL timeout: cycles=%0d limit=60000", cycles);
                $fatal(1, "simulation cycle budget exhausted");
            end
            if (load_done === 1'b1) done_pulses++;
            match    = ioctl_download && (ioctl_index == LOAD_INDEX);
            push_req = ioctl_wr && match;
            m_pop    = !reset && !cpu_ce && (mq.size() != 0) && m_sess;
            e_addr   = cpu_addr;
            e_wdata  = cpu_wdata;
            e_we     = 1'b0;
            if (reset) e_we = 1'b0;
            else if (cpu_ce) e_we = cpu_we && !(m_prot && cpu_addr[15:14] == BASE_HI);
            else if (m_pop) begin
                e_addr  = {BASE_HI, mq[0][21:8]};
                e_wdata = mq[0][7:0];
                e_we    = 1'b1;
            end
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_we", ram_we, e_we);
            if (e_we) chk("ram_wdata", ram_wdata, e_wdata);
            chk("busy", busy, m_sess || m_done || (mq.size() != 0));
            chk("load_done", load_done, m_done);
            chk("ioctl_wait", ioctl_wait, m_wait);
            chk("overflow", overflow, m_ovf);
            chk("cpu_rdata", cpu_rdata, m_rdata);
            // advance the model across the coming clock edge
            if (reset) begin
                mq.delete();
                m_sess = 0; m_fallen = 0; m_done = 0; m_prot = 0;
                m_wait = 0; m_ovf = 0; m_prev_ce = 0; m_prev_dl = 0;
                m_rdata = 8'h00;
            end else begin
                was_empty = (mq.size() == 0);
                nd = 0;
                if (m_done) m_prot = PROT_EN;
                else if (!m_sess) begin
                    if (match) begin m_sess = 1; m_fallen = 0; m_prot = 0; end
                end else if (!m_fallen) begin
                    if (m_prev_dl && !ioctl_download) m_fallen = 1;
                end else if (was_empty) begin
                    m_sess = 0; nd = 1;
                end
                m_done = nd;
                if (m_pop) void'(mq.pop_front());
                if (push_req) begin
                    if (mq.size() < DEPTH) mq.push_back({ioctl_addr, ioctl_dout});
                    else m_ovf = 1;
                end
                m_wait    = (mq.size() >= DEPTH - 1);
                m_rdata   = m_prev_ce ? ram_q : m_rdata;
                m_prev_ce = cpu_ce;
                m_prev_dl = ioctl_download;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk_sys);
        #1;
        ce_cnt++;
        case (ce_mode)
            CE_16:  cpu_ce = (ce_cnt % 16 == 0);
            CE_ALL: cpu_ce = 1'b1;
            CE_RAND: begin
                cpu_ce    = ($urandom_range(0, 2) == 0);
                cpu_addr  = 16'($urandom);
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_wdata = 8'($urandom);
            end
            default: ;
        endcase
    endtask

    task automatic push(input logic [13:0] a, input logic [7:0] d);
        ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
        cyc();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin cyc(); n++; end
        chk("idle_timeout", busy, 0);
    endtask

    // ---------------- scenarios ----------------
    initial begin : stim
        int d0, h0, n;
        logic [7:0] old0, old1;
        logic [7:0] vals [3];
        bit honour;
        vals[0] = 8'hA5; vals[1] = 8'h5A; vals[2] = 8'h3C;

        // reset, then idle
        repeat (3) cyc();
        chk("rst_ram_addr", ram_addr, 16'h1234);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_busy", busy, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_wait", ioctl_wait, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        reset = 1'b0;
        cpu_addr = 16'h2345;
        cyc();
        chk("idle_ram_addr", ram_addr, 16'h2345);

        // 3-byte download with cpu_ce every 16th cycle
        ce_mode = CE_16; ioctl_index = LOAD_INDEX; ioctl_download = 1'b1;
        d0 = done_pulses;
        cyc();
        for (int i = 0; i < 3; i++) push(14'(i), vals[i]);
        repeat (2) cyc();
        ioctl_download = 1'b0;
        wait_idle(60);
        chk("dl3_c000", mem[16'hC000], 8'hA5);
        chk("dl3_c001", mem[16'hC001], 8'h5A);
        chk("dl3_c002", mem[16'hC002], 8'h3C);
        chk("dl3_done_pulses", done_pulses - d0, 1);

        // ce every cycle, driver honours ioctl_wait
        ce_mode = CE_ALL; cpu_we = 1'b0; ioctl_download = 1'b1;
        h0 = hi_writes;
        cyc();
        push(14'h100, 8'h01);
        push(14'h101, 8'h02);
        chk("wait_after_2", ioctl_wait, 0);
        push(14'h102, 8'h03);
        chk("wait_after_3", ioctl_wait, 1);
        repeat (4) cyc();
        chk("no_hi_writes_at_ce", hi_writes - h0, 0);
        ce_mode = CE_MAN; cpu_ce = 1'b0;
        for (int k = 3; k < 5; k++) begin
            n = 0;
            while (ioctl_wait && n < 20) begin cyc(); n++; end
            chk("wait_release", ioctl_wait, 0);
            push(14'(16'h100 + k), 8'(k + 1));
        end
        ioctl_download = 1'b0;
        wait_idle(40);
        chk("honour_overflow", overflow, 0);
        for (int k = 0; k < 5; k++) chk("honour_ram", mem[16'hC100 + 16'(k)], 8'(k + 1));

        // ce every cycle, driver ignores ioctl_wait -> 5th byte dropped
        old0 = mem[16'hC204];
        ce_mode = CE_ALL; ioctl_download = 1'b1;
        cyc();
        for (int k = 0; k < 5; k++) push(14'(16'h200 + k), 8'(8'h11 * (k + 1)));
        chk("ignore_overflow", overflow, 1);
        ce_mode = CE_MAN; cpu_ce = 1'b0;
        repeat (6) cyc();
        chk("overflow_sticky", overflow, 1);
        ioctl_download = 1'b0;
        wait_idle(40);
        for (int k = 0; k < 4; k++) chk("ignore_ram", mem[16'hC200 + 16'(k)], 8'(8'h11 * (k + 1)));
        chk("ignore_dropped", mem[16'hC204], old0);

        // CPU write wins over a non-empty FIFO, then CPU read-back
        ioctl_download = 1'b1; cpu_ce = 1'b1;
        cyc();
        push(14'h030, 8'h99);
        cpu_addr = 16'h4000; cpu_wdata = 8'h77; cpu_we = 1'b1;
        cyc();
        cpu_we = 1'b0; cpu_ce = 1'b0;
        cyc();
        chk("cpu_wins_c030", mem[16'hC030], 8'h99);
        cpu_ce = 1'b1; cpu_addr = 16'h4000;
        cyc();
        cpu_ce = 1'b0;
        cyc();
        chk("cpu_ram_4000", mem[16'h4000], 8'h77);
        chk("cpu_rdata_4000", cpu_rdata, 8'h77);
        ioctl_download = 1'b0;
        wait_idle(20);

        // reset with 2 bytes queued
        old0 = mem[16'hC040]; old1 = mem[16'hC041];
        cpu_ce = 1'b1; ioctl_download = 1'b1;
        cyc();
        push(14'h040, 8'hE1);
        push(14'h041, 8'hE2);
        h0 = hi_writes; d0 = done_pulses;
        reset = 1'b1; ioctl_download = 1'b0; cpu_ce = 1'b0;
        repeat (2) cyc();
        reset = 1'b0;
        repeat (10) cyc();
        chk("rst_q_c040", mem[16'hC040], old0);
        chk("rst_q_c041", mem[16'hC041], old1);
        chk("rst_q_hi_writes", hi_writes - h0, 0);
        chk("rst_q_no_done", done_pulses - d0, 0);
        chk("rst_q_overflow", overflow, 0);
        chk("rst_q_busy", busy, 0);

        // post-load CPU write into the cartridge window
        ioctl_download = 1'b1;
        cyc();
        push(14'h050, 8'h66);
        ioctl_download = 1'b0;
        wait_idle(20);
        chk("prot_load_c050", mem[16'hC050], 8'h66);
        old0 = mem[16'hC010];
        cpu_ce = 1'b1; cpu_addr = 16'hC010; cpu_wdata = 8'hFF; cpu_we = 1'b1;
        cyc();
        cpu_ce = 1'b0; cpu_we = 1'b0;
        cyc();
        chk("prot_c010", mem[16'hC010], PROT_EN ? old0 : 8'hFF);

        // randomized traffic, back-to-back loads (some restart during flush)
        ce_mode = CE_RAND;
        for (int s = 0; s < 8; s++) begin
            honour = 1'($urandom_range(0, 1));
            ioctl_download = 1'b1;
            n = $urandom_range(20, 50);
            for (int c = 0; c < n; c++) begin
                ioctl_index = ($urandom_range(0, 9) == 0) ? 8'd2 : LOAD_INDEX;
                ioctl_wr    = ($urandom_range(0, 1) == 1) && !(honour && ioctl_wait);
                ioctl_addr  = 14'($urandom);
                ioctl_dout  = 8'($urandom);
                cyc();
            end
            ioctl_wr = 1'b0; ioctl_index = LOAD_INDEX; ioctl_download = 1'b0;
            n = $urandom_range(0, 6);
            for (int c = 0; c < n; c++) cyc();
        end
        wait_idle(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ioctl_ram_arbiter.md
# ioctl_ram_arbiter

Single-port arbiter for the 64 KB main RAM. It shares the RAM between the Z80 bus and the HPS cartridge download stream, so the RAM can be a single-port macro instead of a dual-port one. CPU accesses own every `ce` cycle. Download bytes are buffered in a small FIFO and written in the idle cycles between CPU accesses. The block also generates the end-of-load pulse that sets the cartridge-enable flag.

## Interface
Parameters:
- `FIFO_AW`, default 2: log2 of the FIFO depth; default depth is 4 entries.
- `LOAD_INDEX`, default 8'd1: `ioctl_index` value accepted as a cartridge download.
- `BASE_HI`, default 2'b11: RAM address bits [15:14] for downloaded data.

Ports (one clock `clk_sys`; reset `reset` is synchronous and active-high):
- `clk_sys` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `cpu_ce` in 1: CPU clock enable (`ce_3m5`); marks a CPU-owned cycle.
- `cpu_addr` in 16: CPU address.
- `cpu_wdata` in 8: CPU write data.
- `cpu_we` in 1: CPU RAM write request (RAM_WE | EXT_WE).
- `cpu_rdata` out 8: registered RAM read data for the CPU.
- `ioctl_download` in 1: download active.
- `ioctl_index` in 8: download target index.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_addr` in 14: byte offset.
- `ioctl_dout` in 8: byte data.
- `ioctl_wait` out 1: backpressure to the HPS.
- `ram_addr` out 16: RAM address.
- `ram_wdata` out 8: RAM write data.
- `ram_we` out 1: RAM write enable.
- `ram_q` in 8: RAM read data, valid 1 cycle after the address.
- `load_done` out 1: one-cycle pulse when a download is fully committed.
- `busy` out 1: download in progress or FIFO not empty.
- `overflow` out 1: sticky flag, a byte was dropped.

## Operation
- FIFO entries are 22 bits: {addr[13:0], data[7:0]}.
- Push: `ioctl_wr & ioctl_download & (ioctl_index==LOAD_INDEX)`.
- Pop: any cycle with `cpu_ce==0`, FIFO not empty, and state DRAIN or FLUSH.
- A push at full with a pop in the same cycle is accepted.
- A push at full with no pop drops the byte and sets `overflow`. `overflow` clears only on reset.
- Port mux:
  - When `cpu_ce==1`: `ram_addr=cpu_addr`, `ram_wdata=cpu_wdata`, `ram_we=cpu_we`.
  - On a pop cycle: `ram_addr={BASE_HI, head.addr}`, `ram_wdata=head.data`, `ram_we=1`.
  - Otherwise: `ram_addr=cpu_addr`, `ram_we=0`.
- The CPU always wins. No FIFO pop ever occurs on a `cpu_ce` cycle.
- `cpu_rdata`: registered from `ram_q` on the cycle after a `cpu_ce` cycle, then held.
- `ioctl_wait` is registered: 1 when the occupancy after this cycle is ≥ 2^FIFO_AW − 1.
- State machine:
  - IDLE → DRAIN when a matching download is active.
  - DRAIN → FLUSH on a falling edge of `ioctl_download`.
  - FLUSH → DONE when the FIFO is empty and no pop is in flight.
  - DONE → IDLE unconditionally. `load_done`=1 only in DONE.
  - A new download rising while in FLUSH stays in FLUSH. Pops continue, and DONE is still produced before the return to DRAIN.
- `busy` = (state≠IDLE) | FIFO not empty.
- Reset mid-download:
  - The FIFO empties and pointers clear; pending bytes are discarded.
  - State goes to IDLE and `load_done` is not pulsed.
  - `overflow` clears.

## Timing
- Reset values: `cpu_rdata`=0, `ioctl_wait`=0, `load_done`=0, `busy`=0, `overflow`=0, `ram_we`=0, `ram_addr`=`cpu_addr`, FIFO empty, state IDLE.
- `ram_addr`, `ram_wdata` and `ram_we` are combinational from registered FIFO head/state and CPU inputs, with no added latency on the CPU path.
- Download write latency: the byte is in RAM at the earliest 2 cycles after `ioctl_wr` (push edge, then the next non-ce pop cycle).
- CPU read: `cpu_rdata` is valid 2 cycles after the `cpu_ce` cycle (address edge, then capture edge).
- At ce every cycle (fast tape), no pops occur. The FIFO fills and `ioctl_wait` holds the HPS; no data is lost.
- `load_done` asserts 2 cycles after the last pop, or 2 cycles after the download falls if the FIFO is already empty.

## Configuration
- `ARB_ROM_PROTECT_EN` defined:
  - After `load_done`, CPU writes with `cpu_addr[15:14]==BASE_HI` are forced to `ram_we=0` until reset.
  - A new matching download removes the protection.
- Not defined: CPU writes always pass through.

## Test plan
- Reset, then idle: all outputs at reset values; `ram_addr` follows `cpu_addr`.
- Download 3 bytes (addr 0,1,2 = 0xA5,0x5A,0x3C) with `cpu_ce` every 16th cycle, then drop `ioctl_download` → RAM 0xC000–0xC002 hold A5,5A,3C; one `load_done` pulse; `busy` falls.
- `cpu_ce` held 1, 5 `ioctl_wr` back-to-back → `ioctl_wait` rises after the 3rd push; no RAM writes to 0xC000+. When `cpu_ce` drops, the FIFO drains; `overflow` stays 0 because the driver honours `ioctl_wait`.
- Same as the previous case, but the driver ignores `ioctl_wait` → 5th byte dropped, `overflow`=1 and sticky; first 4 bytes written.
- CPU write to 0x4000 with value 0x77 in the same cycle as a non-empty FIFO and `cpu_ce`=1 → RAM[0x4000]=0x77; the FIFO byte is written the next non-ce cycle. A CPU read of 0x4000 returns 0x77 in `cpu_rdata` 2 cycles later.
- Reset asserted with 2 bytes queued → no further RAM writes, no `load_done`. With `ARB_ROM_PROTECT_EN`, a post-load CPU write to 0xC010 leaves RAM unchanged.
